inv_lift_row: RTL and testbench

- Inverse LeGall 5/3 lifting engine for one row. It is the decode-side counterpart of the forward lift_step datapath.
- Reads interleaved wavelet coefficients from a single-port sample RAM: even address = low-pass, odd address = high-pass.
- Undoes the update step on even samples, then undoes the predict step on odd samples, writing results back in place.
- Sits between the coefficient RAM and signed2twoscomplement-style output conversion in the reconstruction path.

---
 rtl/inv_lift_row_pkg.sv | 26 ++
 rtl/inv_lift_row_if.sv | 26 ++
 rtl/inv_lift_row_kernel.sv | 43 ++++
 rtl/inv_lift_row.sv | 118 +++++++++++
 tb/tb_inv_lift_row.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/inv_lift_row_pkg.sv
// Shared types and helpers for the inverse 5/3 lifting engines (row now, column later).
package inv_lift_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_L,
    RD_S,
    RD_R,
    CAP_R,
    WR,
    FIN
  } state_t;

  localparam int CYC_PER_SAMPLE = 5;

  localparam logic PASS_UPD  = 1'b0;
  localparam logic PASS_PRED = 1'b1;

  // Whole-sample symmetric extension: -1 -> 1, row_len -> row_len-2.
  function automatic int mirror_idx(input int idx, input int row_len);
    if (idx < 0) return -idx;
    if (idx >= row_len) return 2 * row_len - 2 - idx;
    return idx;
  endfunction

endpackage

// File: rtl/inv_lift_row_if.sv
// Control handshake plus single-port coefficient RAM bus of the inverse lifting engine.
interface inv_lift_row_if #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 8
);
  logic                     start;
  logic [ADDR_W-1:0]        row_base;
  logic                     busy;
  logic                     done;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_rd;
  logic signed [DATA_W-1:0] mem_rdata;
  logic                     mem_we;
  logic signed [DATA_W-1:0] mem_wdata;

  // master: sequencer / RAM side; slave: the lifting engine
  modport master (
    output start, row_base, mem_rdata,
    input  busy, done, mem_addr, mem_rd, mem_we, mem_wdata
  );

  modport slave (
    input  start, row_base, mem_rdata,
    output busy, done, mem_addr, mem_rd, mem_we, mem_wdata
  );
endinterface

// File: rtl/inv_lift_row_kernel.sv
// Combinational inverse 5/3 lifting kernel: undo update (pass 0) or undo predict (pass 1).
module inv_lift_kernel
  import inv_lift_pkg::*;
#(
  parameter int DATA_W = 9
) (
  input  logic signed [DATA_W-1:0] l,
  input  logic signed [DATA_W-1:0] s,
  input  logic signed [DATA_W-1:0] r,
  input  logic                     pass,
  output logic signed [DATA_W-1:0] res
);
  localparam int SUM_W = DATA_W + 2;

  function automatic logic signed [SUM_W-1:0] upd_term(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
    logic signed [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b) + SUM_W'(2);
    return sum >>> 2;
  endfunction

  function automatic logic signed [SUM_W-1:0] pred_term(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
    logic signed [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b);
    return sum >>> 1;
  endfunction

  // Results wrap to the sample width; no saturation on the decode path.
  function automatic logic signed [DATA_W-1:0] wrap(input logic signed [SUM_W-1:0] v);
    return DATA_W'(v);
  endfunction

  logic signed [SUM_W-1:0] full;

  always_comb begin
    full = '0;
    if (pass == PASS_UPD) full = SUM_W'(s) - upd_term(l, r);
    else                  full = SUM_W'(s) + pred_term(l, r);
    res = wrap(full);
  end

endmodule

// File: rtl/inv_lift_row.sv
// Inverse LeGall 5/3 row engine: in-place read-modify-write over one interleaved row.
module inv_lift_row
  import inv_lift_pkg::*;
#(
  parameter int DATA_W  = 9,
  parameter int ROW_LEN = 8,
  parameter int ADDR_W  = 8
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  inv_lift_row_if.slave  bus
);
  localparam int K_W = $clog2(ROW_LEN) + 1;

  state_t                   state, state_nxt;
  logic [ADDR_W-1:0]        row_base;
  logic [K_W-1:0]           k;
  logic                     pass;
  logic signed [DATA_W-1:0] l_p0, s_p0, r_p0;
  logic signed [DATA_W-1:0] res;
  logic [ADDR_W-1:0]        addr_l, addr_s, addr_r;
  logic                     last_k;

  assign addr_l = row_base + ADDR_W'(mirror_idx(int'(k) - 1, ROW_LEN));
  assign addr_s = row_base + ADDR_W'(int'(k));
  assign addr_r = row_base + ADDR_W'(mirror_idx(int'(k) + 1, ROW_LEN));
  assign last_k = (int'(k) + 2 >= ROW_LEN);

  inv_lift_kernel #(.DATA_W(DATA_W)) u_kernel (
    .l    (l_p0),
    .s    (s_p0),
    .r    (r_p0),
    .pass (pass),
    .res  (res)
  );

  // Operand capture trails each read by one cycle (synchronous RAM latency).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      row_base <= '0;
      k        <= '0;
      pass     <= PASS_UPD;
      l_p0     <= '0;
      s_p0     <= '0;
      r_p0     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.start) begin
          row_base <= bus.row_base;
          k        <= '0;
          pass     <= PASS_UPD;
        end
        RD_S:  l_p0 <= bus.mem_rdata;
        RD_R:  s_p0 <= bus.mem_rdata;
        CAP_R: r_p0 <= bus.mem_rdata;
        WR: begin
          if (!last_k) begin
            k <= k + K_W'(2);
          end else if (pass == PASS_UPD) begin
            k    <= K_W'(1);
            pass <= PASS_PRED;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      IDLE: if (bus.start) state_nxt = RD_L;
      RD_L: begin
        bus.busy     = 1'b1;
        bus.mem_rd   = 1'b1;
        bus.mem_addr = addr_l;
        state_nxt    = RD_S;
      end
      RD_S: begin
        bus.busy     = 1'b1;
        bus.mem_rd   = 1'b1;
        bus.mem_addr = addr_s;
        state_nxt    = RD_R;
      end
      RD_R: begin
        bus.busy     = 1'b1;
        bus.mem_rd   = 1'b1;
        bus.mem_addr = addr_r;
        state_nxt    = CAP_R;
      end
      CAP_R: begin
        bus.busy  = 1'b1;
        state_nxt = WR;
      end
      WR: begin
        bus.busy      = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr_s;
        bus.mem_wdata = res;
        state_nxt     = (last_k && pass == PASS_PRED) ? FIN : RD_L;
      end
      FIN: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_inv_lift_row.sv
// Bench for inv_lift_row: ROW_LEN=4 and ROW_LEN=8 engines on behavioural RAMs, bus-event scoreboard.
module tb_inv_lift_row;
  import inv_lift_pkg::*;

  localparam int DW = 9;
  localparam int AW = 8;

  typedef struct {
    bit we;
    int addr;
    int data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inv_lift_row_if #(.DATA_W(DW), .ADDR_W(AW)) b4 ();
  inv_lift_row_if #(.DATA_W(DW), .ADDR_W(AW)) b8 ();

  inv_lift_row #(.DATA_W(DW), .ROW_LEN(4), .ADDR_W(AW)) dut4 (.clk_i(clk), .rst_n_i(rst_n), .bus(b4));
  inv_lift_row #(.DATA_W(DW), .ROW_LEN(8), .ADDR_W(AW)) dut8 (.clk_i(clk), .rst_n_i(rst_n), .bus(b8));

  logic signed [DW-1:0] ram4 [256];
  logic signed [DW-1:0] ram8 [256];
  logic                 ld_we, ld_sel;
  logic [AW-1:0]        ld_addr;
  logic signed [DW-1:0] ld_data;

  int   total = 0;
  int   bad = 0;
  ev_t  q4[$];
  ev_t  q8[$];
  int   rd_log[$];
  int   wr_cnt[2];
  bit   active[2];
  int   done_cnt[2];

  // Single-port RAMs with one-cycle read latency, plus a bench load port.
  always @(posedge clk) begin
    if (ld_we && !ld_sel) ram4[ld_addr] <= ld_data;
    if (ld_we && ld_sel)  ram8[ld_addr] <= ld_data;
    if (b4.mem_we) ram4[b4.mem_addr] <= b4.mem_wdata;
    if (b8.mem_we) ram8[b8.mem_addr] <= b8.mem_wdata;
    b4.mem_rdata <= b4.mem_rd ? ram4[b4.mem_addr] : '0;
    b8.mem_rdata <= b8.mem_rd ? ram8[b8.mem_addr] : '0;
  end

  task automatic check_eq(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input bit sel, input bit we, input int addr, input int data);
    ev_t e;
    e.we = we;
    e.addr = addr & 255;
    e.data = data;
    if (sel) q8.push_back(e);
    else     q4.push_back(e);
  endtask

  // Reference: in-place inverse lift on a copy of the RAM, emitting the expected bus events.
  task automatic model_row(input bit sel, input logic [AW-1:0] base);
    int n, li, ri, res;
    int img[8];
    n = sel ? 8 : 4;
    for (int i = 0; i < n; i++)
      img[i] = sel ? int'(ram8[AW'(int'(base) + i)]) : int'(ram4[AW'(int'(base) + i)]);
    for (int p = 0; p < 2; p++) begin
      for (int k = p; k < n; k += 2) begin
        li = (k == 0) ? 1 : k - 1;
        ri = (k == n - 1) ? n - 2 : k + 1;
        push_ev(sel, 1'b0, int'(base) + li, 0);
        push_ev(sel, 1'b0, int'(base) + k, 0);
        push_ev(sel, 1'b0, int'(base) + ri, 0);
        if (p == 0) res = img[k] - ((img[li] + img[ri] + 2) >>> 2);
        else        res = img[k] + ((img[li] + img[ri]) >>> 1);
        res = ((res + 256) & 511) - 256;
        img[k] = res;
        push_ev(sel, 1'b1, int'(base) + k, res);
      end
    end
    active[sel] = 1'b1;
  endtask

  task automatic mon(input bit sel, input logic rd, input logic we, input logic done,
                     input logic [AW-1:0] addr, input logic signed [DW-1:0] wd, input int n);
    ev_t e;
    int  qs;
    qs = sel ? q8.size() : q4.size();
    if (rd || we) begin
      check_eq("rd_we_excl", {31'b0, rd & we}, 0);
      check_eq("access_pending", int'(qs != 0), 1);
      if (qs != 0) begin
        if (sel) e = q8.pop_front();
        else     e = q4.pop_front();
        check_eq("acc_kind", {31'b0, we}, {31'b0, e.we});
        check_eq("acc_addr", {24'b0, addr}, e.addr);
        if (we) check_eq("wr_data", wd, e.data);
      end
      if (we) wr_cnt[sel]++;
      if (sel && rd) rd_log.push_back(int'(addr));
    end
    if (done) begin
      check_eq("done_expected", {31'b0, active[sel]}, 1);
      check_eq("writes_per_row", wr_cnt[sel], n);
      wr_cnt[sel] = 0;
      active[sel] = 1'b0;
      done_cnt[sel]++;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(1'b0, b4.mem_rd, b4.mem_we, b4.done, b4.mem_addr, b4.mem_wdata, 4);
      mon(1'b1, b8.mem_rd, b8.mem_we, b8.done, b8.mem_addr, b8.mem_wdata, 8);
    end
  end

  task automatic set_start(input bit sel, input logic v, input logic [AW-1:0] base);
    if (sel) begin b8.start = v; b8.row_base = base; end
    else     begin b4.start = v; b4.row_base = base; end
  endtask

  task automatic load(input bit sel, input logic [AW-1:0] a, input int v);
    @(negedge clk);
    ld_we = 1'b1; ld_sel = sel; ld_addr = a; ld_data = DW'(v);
    @(posedge clk);
    #1 ld_we = 1'b0;
  endtask

  // Starts a row, optionally pulses start at cycles p1..p3, and checks busy/done timing.
  task automatic run_row(input bit sel, input logic [AW-1:0] base, input int p1, input int p2, input int p3);
    int n, fin, dc, dn;
    logic bsy, dne;
    n = sel ? 8 : 4;
    fin = CYC_PER_SAMPLE * n + 1;
    dc = -1;
    dn = 0;
    model_row(sel, base);
    rd_log.delete();
    @(negedge clk);
    set_start(sel, 1'b1, base);
    @(posedge clk);
    #1 set_start(sel, 1'b0, base);
    for (int c = 1; c <= fin + 3; c++) begin
      if (c == p1 || c == p2 || c == p3) set_start(sel, 1'b1, base + 8'h10);
      @(negedge clk);
      bsy = sel ? b8.busy : b4.busy;
      dne = sel ? b8.done : b4.done;
      if (dne) begin
        dn++;
        if (dc < 0) dc = c;
      end
      if (c == 1)       check_eq("busy_first", {31'b0, bsy}, 1);
      if (c == fin - 1) check_eq("busy_last", {31'b0, bsy}, 1);
      if (c == fin)     check_eq("busy_fin", {31'b0, bsy}, 0);
      @(posedge clk);
      #1 set_start(sel, 1'b0, base);
    end
    check_eq("done_cycle", dc, fin);
    check_eq("done_count", dn, 1);
    check_eq("q_drained", sel ? q8.size() : q4.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag, input bit sel);
    if (sel) begin
      check_eq({tag, "_busy"}, {31'b0, b8.busy}, 0);
      check_eq({tag, "_done"}, {31'b0, b8.done}, 0);
      check_eq({tag, "_rd"}, {31'b0, b8.mem_rd}, 0);
      check_eq({tag, "_we"}, {31'b0, b8.mem_we}, 0);
      check_eq({tag, "_addr"}, {24'b0, b8.mem_addr}, 0);
      check_eq({tag, "_wdata"}, b8.mem_wdata, 0);
    end else begin
      check_eq({tag, "_busy"}, {31'b0, b4.busy}, 0);
      check_eq({tag, "_done"}, {31'b0, b4.done}, 0);
      check_eq({tag, "_rd"}, {31'b0, b4.mem_rd}, 0);
      check_eq({tag, "_we"}, {31'b0, b4.mem_we}, 0);
      check_eq({tag, "_addr"}, {24'b0, b4.mem_addr}, 0);
      check_eq({tag, "_wdata"}, b4.mem_wdata, 0);
    end
  endtask

  initial begin
    int rt_in[4]  = '{120, 103, 206, 68};
    int rt_exp[4] = '{68, 218, 163, 231};
    int ng_in[4]  = '{0, -3, 0, -2};
    int ng_exp[4] = '{1, -2, 1, -1};
    int dones;
    set_start(1'b0, 1'b0, '0);
    set_start(1'b1, 1'b0, '0);
    ld_we = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    wr_cnt = '{0, 0}; active = '{0, 0}; done_cnt = '{0, 0};

    repeat (3) @(posedge clk);
    #1 check_idle_outputs("rst4", 1'b0);
    check_idle_outputs("rst8", 1'b1);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) load(1'b0, AW'(i), rt_in[i]);
    run_row(1'b0, 8'h00, -1, -1, -1);
    for (int i = 0; i < 4; i++) check_eq($sformatf("rt_x%0d", i), ram4[i], rt_exp[i]);

    for (int i = 0; i < 4; i++) load(1'b0, AW'(i), ng_in[i]);
    run_row(1'b0, 8'h00, -1, -1, -1);
    for (int i = 0; i < 4; i++) check_eq($sformatf("neg_x%0d", i), ram4[i], ng_exp[i]);

    for (int i = 0; i < 8; i++) load(1'b1, AW'(8'hFC + i), int'($urandom_range(0, 511)) - 256);
    run_row(1'b1, 8'hFC, -1, -1, -1);
    check_eq("bnd_k0_l", rd_log[0], 'hFD);
    check_eq("bnd_k0_s", rd_log[1], 'hFC);
    check_eq("bnd_k0_r", rd_log[2], 'hFD);
    check_eq("bnd_k7_l", rd_log[21], 'h02);
    check_eq("bnd_k7_s", rd_log[22], 'h03);
    check_eq("bnd_k7_r", rd_log[23], 'h02);

    for (int i = 0; i < 8; i++) load(1'b1, AW'(8'h40 + i), int'($urandom_range(0, 511)) - 256);
    run_row(1'b1, 8'h40, 3, 40, 41);
    check_idle_outputs("after_fin8", 1'b1);

    for (int i = 0; i < 8; i++) load(1'b1, AW'(8'h80 + i), int'($urandom_range(0, 511)) - 256);
    dones = done_cnt[1];
    model_row(1'b1, 8'h80);
    @(negedge clk);
    set_start(1'b1, 1'b1, 8'h80);
    @(posedge clk);
    #1 set_start(1'b1, 1'b0, 8'h80);
    repeat (11) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_idle_outputs("abort8", 1'b1);
    q8.delete();
    wr_cnt[1] = 0;
    active[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("post_abort8", 1'b1);
    check_eq("abort_no_done", done_cnt[1], dones);
    run_row(1'b1, 8'h80, -1, -1, -1);

    for (int i = 0; i < 4; i++) load(1'b0, AW'(8'hFE + i), int'($urandom_range(0, 511)) - 256);
    run_row(1'b0, 8'hFE, 2, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
